axi_rr_arbiter: RTL and testbench

Two-requester arbiter that shares one AXI-style single-beat port (AW/W/B write path, AR/R read path, rdy/ack handshakes) between NREQ upstream masters. Write and read paths are arbitrated independently, each by its own FSM with a registered grant. The block sits between the requesting engines and the single downstream slave port driven by the testbench/slave model. One transaction per path is in flight at a time.

---
 rtl/axi_rr_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_axi_rr_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter.sv
// Shares one single-beat AXI-style port between NREQ requesters; independent write and read arbiters.
// Define AXI_ARB_RR_EN for round-robin selection; otherwise the lowest requesting index wins.
//
// state  | meaning
// W_IDLE | no write owner, arbitrate AW requests
// W_ADDR | forward AW of wgnt
// W_DATA | forward W of wgnt
// W_RESP | return B to wgnt
// R_IDLE | no read owner, arbitrate AR requests
// R_ADDR | forward AR of rgnt
// R_DATA | return R to rgnt
module axi_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 6,
    parameter int DW   = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREQ-1:0]          s_aw_rdy_i,
    output logic [NREQ-1:0]          s_aw_ack_o,
    input  logic [NREQ-1:0][AW-1:0]  s_aw_i,
    input  logic [NREQ-1:0]          s_w_rdy_i,
    output logic [NREQ-1:0]          s_w_ack_o,
    input  logic [NREQ-1:0][DW-1:0]  s_w_i,
    output logic [NREQ-1:0]          s_b_rdy_o,
    input  logic [NREQ-1:0]          s_b_ack_i,
    output logic [1:0]               s_b_o,
    input  logic [NREQ-1:0]          s_ar_rdy_i,
    output logic [NREQ-1:0]          s_ar_ack_o,
    input  logic [NREQ-1:0][AW-1:0]  s_ar_i,
    output logic [NREQ-1:0]          s_r_rdy_o,
    input  logic [NREQ-1:0]          s_r_ack_i,
    output logic [DW-1:0]            s_r_o,
    output logic                     m_aw_rdy_o,
    input  logic                     m_aw_ack_i,
    output logic [AW-1:0]            m_aw_o,
    output logic                     m_w_rdy_o,
    input  logic                     m_w_ack_i,
    output logic [DW-1:0]            m_w_o,
    input  logic                     m_b_rdy_i,
    output logic                     m_b_ack_o,
    input  logic [1:0]               m_b_i,
    output logic                     m_ar_rdy_o,
    input  logic                     m_ar_ack_i,
    output logic [AW-1:0]            m_ar_o,
    input  logic                     m_r_rdy_i,
    output logic                     m_r_ack_o,
    input  logic [DW-1:0]            m_r_i
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

    wstate_e         wstate_q, wstate_d;
    rstate_e         rstate_q, rstate_d;
    logic [GW-1:0]   wgnt_q, wgnt_d, rgnt_q, rgnt_d;

`ifdef AXI_ARB_RR_EN
    logic [GW-1:0]   wlast_q, wlast_d, rlast_q, rlast_d;

    // Search starts one past the last owner so every requester gets a turn.
    function automatic logic [GW-1:0] pick(input logic [NREQ-1:0] req, input logic [GW-1:0] last);
        logic found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            int idx;
            idx = (int'(last) + i) % NREQ;
            if (!found && req[GW'(idx)]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
    endfunction
`else
    function automatic logic [GW-1:0] pick(input logic [NREQ-1:0] req);
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[GW'(i)]) pick = GW'(i);
        end
    endfunction
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            wgnt_q   <= '0;
            rgnt_q   <= '0;
`ifdef AXI_ARB_RR_EN
            wlast_q  <= GW'(NREQ - 1);
            rlast_q  <= GW'(NREQ - 1);
`endif
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            wgnt_q   <= wgnt_d;
            rgnt_q   <= rgnt_d;
`ifdef AXI_ARB_RR_EN
            wlast_q  <= wlast_d;
            rlast_q  <= rlast_d;
`endif
        end
    end

    assign s_b_o = m_b_i;
    assign s_r_o = m_r_i;

    always_comb begin
        wstate_d   = wstate_q;
        wgnt_d     = wgnt_q;
`ifdef AXI_ARB_RR_EN
        wlast_d    = wlast_q;
`endif
        s_aw_ack_o = '0;
        s_w_ack_o  = '0;
        s_b_rdy_o  = '0;
        m_aw_rdy_o = 1'b0;
        m_aw_o     = '0;
        m_w_rdy_o  = 1'b0;
        m_w_o      = '0;
        m_b_ack_o  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (|s_aw_rdy_i) begin
`ifdef AXI_ARB_RR_EN
                    wgnt_d = pick(s_aw_rdy_i, wlast_q);
`else
                    wgnt_d = pick(s_aw_rdy_i);
`endif
                    wstate_d = W_ADDR;
                end
            end
            W_ADDR: begin
                m_aw_rdy_o         = s_aw_rdy_i[wgnt_q];
                m_aw_o             = s_aw_i[wgnt_q];
                s_aw_ack_o[wgnt_q] = m_aw_ack_i;
                if (s_aw_rdy_i[wgnt_q] && m_aw_ack_i) wstate_d = W_DATA;
            end
            W_DATA: begin
                m_w_rdy_o         = s_w_rdy_i[wgnt_q];
                m_w_o             = s_w_i[wgnt_q];
                s_w_ack_o[wgnt_q] = m_w_ack_i;
                if (s_w_rdy_i[wgnt_q] && m_w_ack_i) wstate_d = W_RESP;
            end
            W_RESP: begin
                s_b_rdy_o[wgnt_q] = m_b_rdy_i;
                m_b_ack_o         = s_b_ack_i[wgnt_q];
                if (m_b_rdy_i && s_b_ack_i[wgnt_q]) begin
                    wstate_d = W_IDLE;
`ifdef AXI_ARB_RR_EN
                    wlast_d  = wgnt_q;
`endif
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d   = rstate_q;
        rgnt_d     = rgnt_q;
`ifdef AXI_ARB_RR_EN
        rlast_d    = rlast_q;
`endif
        s_ar_ack_o = '0;
        s_r_rdy_o  = '0;
        m_ar_rdy_o = 1'b0;
        m_ar_o     = '0;
        m_r_ack_o  = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (|s_ar_rdy_i) begin
`ifdef AXI_ARB_RR_EN
                    rgnt_d = pick(s_ar_rdy_i, rlast_q);
`else
                    rgnt_d = pick(s_ar_rdy_i);
`endif
                    rstate_d = R_ADDR;
                end
            end
            R_ADDR: begin
                m_ar_rdy_o         = s_ar_rdy_i[rgnt_q];
                m_ar_o             = s_ar_i[rgnt_q];
                s_ar_ack_o[rgnt_q] = m_ar_ack_i;
                if (s_ar_rdy_i[rgnt_q] && m_ar_ack_i) rstate_d = R_DATA;
            end
            R_DATA: begin
                s_r_rdy_o[rgnt_q] = m_r_rdy_i;
                m_r_ack_o         = s_r_ack_i[rgnt_q];
                if (m_r_rdy_i && s_r_ack_i[rgnt_q]) begin
                    rstate_d = R_IDLE;
`ifdef AXI_ARB_RR_EN
                    rlast_d  = rgnt_q;
`endif
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter; a negedge monitor checks forwarded transfers against queued expectations.
module tb_axi_rr_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 6;
    localparam int DW   = 32;

    typedef struct {
        int              g;
        logic [AW-1:0]   a;
        logic [DW-1:0]   d;
    } txn_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NREQ-1:0]          s_aw_rdy, s_aw_ack, s_w_rdy, s_w_ack, s_b_rdy, s_b_ack;
    logic [NREQ-1:0]          s_ar_rdy, s_ar_ack, s_r_rdy, s_r_ack;
    logic [NREQ-1:0][AW-1:0]  s_aw, s_ar;
    logic [NREQ-1:0][DW-1:0]  s_w;
    logic [1:0]               s_b, m_b;
    logic [DW-1:0]            s_r, m_r, m_w;
    logic                     m_aw_rdy, m_aw_ack, m_w_rdy, m_w_ack, m_b_rdy, m_b_ack;
    logic                     m_ar_rdy, m_ar_ack, m_r_rdy, m_r_ack;
    logic [AW-1:0]            m_aw, m_ar;

    int   checks = 0;
    int   errors = 0;
    txn_t wq[$];
    txn_t rq[$];
    logic [NREQ-1:0] hs_aw, hs_w, hs_ar;

    always #5 clk = ~clk;

    axi_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_aw_rdy_i(s_aw_rdy), .s_aw_ack_o(s_aw_ack), .s_aw_i(s_aw),
        .s_w_rdy_i(s_w_rdy), .s_w_ack_o(s_w_ack), .s_w_i(s_w),
        .s_b_rdy_o(s_b_rdy), .s_b_ack_i(s_b_ack), .s_b_o(s_b),
        .s_ar_rdy_i(s_ar_rdy), .s_ar_ack_o(s_ar_ack), .s_ar_i(s_ar),
        .s_r_rdy_o(s_r_rdy), .s_r_ack_i(s_r_ack), .s_r_o(s_r),
        .m_aw_rdy_o(m_aw_rdy), .m_aw_ack_i(m_aw_ack), .m_aw_o(m_aw),
        .m_w_rdy_o(m_w_rdy), .m_w_ack_i(m_w_ack), .m_w_o(m_w),
        .m_b_rdy_i(m_b_rdy), .m_b_ack_o(m_b_ack), .m_b_i(m_b),
        .m_ar_rdy_o(m_ar_rdy), .m_ar_ack_i(m_ar_ack), .m_ar_o(m_ar),
        .m_r_rdy_i(m_r_rdy), .m_r_ack_o(m_r_ack), .m_r_i(m_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ends one cycle: handshakes seen this cycle retire the requester's valid after the edge.
    task automatic cyc();
        @(negedge clk);
        hs_aw = s_aw_rdy & s_aw_ack;
        hs_w  = s_w_rdy & s_w_ack;
        hs_ar = s_ar_rdy & s_ar_ack;
        @(posedge clk);
        #1;
        s_aw_rdy = s_aw_rdy & ~hs_aw;
        s_w_rdy  = s_w_rdy & ~hs_w;
        s_ar_rdy = s_ar_rdy & ~hs_ar;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic req_write(input int g, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        s_aw[g] = a;
        s_w[g]  = d;
        s_aw_rdy[g] = 1'b1;
        s_w_rdy[g]  = 1'b1;
        t.g = g; t.a = a; t.d = d;
        wq.push_back(t);
    endtask

    always @(negedge clk) begin
        if (m_aw_rdy && m_aw_ack) begin
            checks++;
            assert (wq.size() > 0) else begin errors++; $error("FAIL aw_unexpected: observed %0h expected none", m_aw); end
            if (wq.size() > 0) begin
                chk("mon_aw_addr", 32'(m_aw), 32'(wq[0].a));
                chk("mon_aw_ack", 32'(s_aw_ack), 32'(2'b01 << wq[0].g));
            end
        end
        if (m_w_rdy && m_w_ack && wq.size() > 0) begin
            chk("mon_w_data", m_w, wq[0].d);
            chk("mon_w_ack", 32'(s_w_ack), 32'(2'b01 << wq[0].g));
            void'(wq.pop_front());
        end
        if (m_ar_rdy && m_ar_ack && rq.size() > 0)
            chk("mon_ar_addr", 32'(m_ar), 32'(rq[0].a));
        if (m_r_rdy && m_r_ack) begin
            checks++;
            assert (rq.size() > 0) else begin errors++; $error("FAIL r_unexpected: observed %0h expected none", s_r); end
            if (rq.size() > 0) begin
                chk("mon_r_data", s_r, rq[0].d);
                chk("mon_r_rdy", 32'(s_r_rdy), 32'(2'b01 << rq[0].g));
                void'(rq.pop_front());
            end
        end
    end

    initial begin
        txn_t rt;
        int   g;
        rst_n = 1'b0;
        s_aw_rdy = '0; s_w_rdy = '0; s_ar_rdy = '0;
        s_aw = '0; s_w = '0; s_ar = '0;
        s_b_ack = '1; s_r_ack = '1;
        m_aw_ack = 1'b1; m_w_ack = 1'b1; m_ar_ack = 1'b1;
        m_b_rdy = 1'b1; m_r_rdy = 1'b1;
        m_b = 2'b00; m_r = '0;
        #1;
        chk("rst_outputs", {m_aw_rdy, m_w_rdy, m_ar_rdy, m_b_ack, m_r_ack, s_aw_ack, s_w_ack, s_b_rdy, s_ar_ack, s_r_rdy}, 32'h0);
        chk("rst_m_aw", 32'(m_aw), 32'h0);
        chk("rst_m_w", m_w, 32'h0);
        chk("rst_m_ar", 32'(m_ar), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Single write
        req_write(0, 6'h05, 32'hDEADBEEF);
        mid(); chk("w1_arb_idle", 32'(m_aw_rdy), 32'h0);
        cyc(); mid(); chk("w1_aw_rdy", 32'(m_aw_rdy), 32'h1); chk("w1_aw", 32'(m_aw), 32'h05);
        cyc(); mid(); chk("w1_w_rdy", 32'(m_w_rdy), 32'h1); chk("w1_w", m_w, 32'hDEADBEEF);
        cyc(); mid(); chk("w1_b_rdy", 32'(s_b_rdy), 32'h1); chk("w1_b", 32'(s_b), 32'h0);
        chk("w1_m_b_ack", 32'(m_b_ack), 32'h1);
        cyc(); mid(); chk("w1_idle", 32'({s_b_rdy, m_aw_rdy, m_w_rdy}), 32'h0);

        // Both requesters write repeatedly from a fresh reset
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        s_aw[0] = 6'h10; s_aw[1] = 6'h20; s_w[0] = 32'hA0000000; s_w[1] = 32'hB0000000;
        s_aw_rdy = 2'b11; s_w_rdy = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef AXI_ARB_RR_EN
            g = k % 2;
`else
            g = 0;
`endif
            rt.g = g; rt.a = s_aw[g]; rt.d = s_w[g];
            wq.push_back(rt);
            cyc(); mid(); chk("sim_gnt", 32'(s_aw_ack), 32'(2'b01 << g));
            cyc(); cyc(); mid(); chk("sim_b_rdy", 32'(s_b_rdy), 32'(2'b01 << g));
            cyc();
            if (k < 3) begin
                s_aw[g] = s_aw[g] + 6'h1;
                s_w[g]  = s_w[g] + 32'h1;
                s_aw_rdy[g] = 1'b1;
                s_w_rdy[g]  = 1'b1;
            end
        end
        s_aw_rdy = '0; s_w_rdy = '0;

        // Concurrent write from req0 and read from req1
        req_write(0, 6'h21, 32'h00C0FFEE);
        s_ar[1] = 6'h12; s_ar_rdy[1] = 1'b1; m_r = 32'h123;
        rt.g = 1; rt.a = 6'h12; rt.d = 32'h123;
        rq.push_back(rt);
        cyc(); mid();
        chk("cc_aw_ack", 32'(s_aw_ack), 32'h1); chk("cc_ar_ack", 32'(s_ar_ack), 32'h2);
        chk("cc_m_ar", 32'(m_ar), 32'h12);
        cyc(); mid(); chk("cc_r_rdy", 32'(s_r_rdy), 32'h2); chk("cc_r", s_r, 32'h123);
        cyc(); mid(); chk("cc_r_idle", 32'(s_r_rdy), 32'h0); chk("cc_b_rdy", 32'(s_b_rdy), 32'h1);
        cyc();

        // W backpressure
        req_write(1, 6'h33, 32'hCAFEF00D);
        m_w_ack = 1'b0;
        cyc(); cyc();
        for (int k = 0; k < 5; k++) begin
            mid(); chk("bp_w_rdy", 32'(m_w_rdy), 32'h1); chk("bp_w_ack", 32'(s_w_ack), 32'h0);
            cyc();
        end
        m_w_ack = 1'b1;
        mid(); chk("bp_w_xfer", 32'(s_w_ack), 32'h2); chk("bp_w", m_w, 32'hCAFEF00D);
        cyc(); mid(); chk("bp_b_rdy", 32'(s_b_rdy), 32'h2);
        cyc();

        // Reset during W_DATA
        req_write(0, 6'h07, 32'h1);
        m_w_ack = 1'b0;
        cyc(); cyc();
        #1; chk("rm_in_data", 32'(m_w_rdy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rm_outputs", {m_aw_rdy, m_w_rdy, m_ar_rdy, m_b_ack, m_r_ack, s_aw_ack, s_w_ack, s_b_rdy, s_ar_ack, s_r_rdy}, 32'h0);
        chk("rm_m_w", m_w, 32'h0);
        wq.delete();
        cyc();
        rst_n = 1'b1;
        s_aw_rdy = '0; s_w_rdy = '0; m_w_ack = 1'b1;
        req_write(1, 6'h2A, 32'h12345678);
        mid(); chk("rm_idle", 32'(m_aw_rdy), 32'h0);
        cyc(); mid(); chk("rm_gnt1", 32'(s_aw_ack), 32'h2); chk("rm_aw", 32'(m_aw), 32'h2A);
        cyc(); cyc(); mid(); chk("rm_b_rdy", 32'(s_b_rdy), 32'h2);
        cyc();

        // Requester drops AW valid while granted
        req_write(0, 6'h0C, 32'h00000C0C);
        cyc();
        s_aw_rdy[0] = 1'b0;
        mid(); chk("drop_aw_rdy0", 32'(m_aw_rdy), 32'h0);
        cyc(); mid(); chk("drop_aw_rdy1", 32'(m_aw_rdy), 32'h0); chk("drop_hold", 32'(s_aw_ack), 32'h1);
        cyc();
        s_aw_rdy[0] = 1'b1;
        mid(); chk("drop_resume", 32'(m_aw_rdy), 32'h1); chk("drop_aw", 32'(m_aw), 32'h0C);
        cyc(); mid(); chk("drop_w_rdy", 32'(m_w_rdy), 32'h1);
        cyc(); cyc();
        mid(); chk("end_idle", 32'({s_b_rdy, m_aw_rdy, m_w_rdy, m_ar_rdy}), 32'h0);
        chk("wq_drained", 32'(wq.size()), 32'h0);
        chk("rq_drained", 32'(rq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
